// File: rtl/uart_pkg.sv
// Framing definitions shared by the UART transmit and receive paths so both ends
// agree on line levels and frame sequencing.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte handshake plus serial line of the UART transmitter.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_out;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_out,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_out,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/tx_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit with a one-cycle tick.
module tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, STOP_BITS stop bits.
// All outputs are registered from the next-state values.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned STOP_BITS    = 1
) (
    input logic      clk,
    input logic      n_rst,
    uart_tx_if.slave bus
);

    localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
    localparam logic [IdxW-1:0] LastData = IdxW'(DATA_BITS - 1);
    localparam logic [IdxW-1:0] LastStop = IdxW'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 out_q, out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick;

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (state_q == StIdle),
        .enable(state_q != StIdle),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.tx_start) begin
                    shreg_d = bus.tx_data;
                    idx_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) state_d = StData;
            end
            StData: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == LastData) begin
                        idx_d   = '0;
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StStop: begin
                // idx is reused to count stop bits
                if (tick) begin
                    if (idx_q == LastStop) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
        unique case (state_d)
            StStart: out_d = START_BIT;
            StData:  out_d = shreg_d[0];
            StStop:  out_d = STOP_BIT;
            default: out_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            idx_q   <= '0;
            out_q   <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx_out  = out_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames, expected bytes queued at issue and checked by
// a receiver-model monitor that decodes the serial line.
module tb_uart_tx;

    localparam int unsigned DB  = 8;
    localparam int unsigned CPB = 10;
    localparam int unsigned SB  = 1;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    uart_tx_if #(.DATA_BITS(DB)) bus ();

    uart_tx #(
        .DATA_BITS   (DB),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         errors    = 0;
    int         checks    = 0;
    int         done_seen = 0;
    int         done_exp  = 0;
    bit         rst_seen  = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge n_rst) rst_seen = 1'b1;

    always @(negedge clk) begin
        if (n_rst === 1'b1 && bus.tx_done === 1'b1) done_seen++;
    end

    // Receiver model: samples mid-bit, checks framing and done timing, pops expected byte.
    initial begin : monitor
        logic [7:0] got;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1 && bus.tx_out === 1'b0) begin
                rst_seen = 1'b0;
                got      = '0;
                repeat (CPB / 2 - 1) @(negedge clk);
                if (!rst_seen) check("rx_start_bit", bus.tx_out, 0);
                for (int i = 0; i < DB; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = bus.tx_out;
                end
                for (int s = 0; s < SB; s++) begin
                    repeat (CPB) @(negedge clk);
                    if (!rst_seen) check("rx_framing_stop", bus.tx_out, 1);
                end
                repeat (CPB - CPB / 2) @(negedge clk);
                if (!rst_seen) check("done_not_early", bus.tx_done, 0);
                @(negedge clk);
                if (!rst_seen) begin
                    check("done_pulse", bus.tx_done, 1);
                    check("done_busy_low", bus.tx_busy, 0);
                    check("done_line_high", bus.tx_out, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected_frame: got %0h expected none", got);
                    end else begin
                        want = exp_q.pop_front();
                        check("rx_byte", got, want);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        exp_q.push_back(d);
        done_exp++;
        @(negedge clk);
        bus.tx_start = 1'b0;
        bus.tx_data  = ~d;
        check("accept_line_low", bus.tx_out, 0);
        check("accept_busy", bus.tx_busy, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.tx_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [9:0] pat;
        int         n;
        pat          = 10'b1101001010;
        bus.tx_start = 1'b0;
        bus.tx_data  = '0;

        // Reset state, then long idle
        repeat (3) @(negedge clk);
        check("reset_line", bus.tx_out, 1);
        check("reset_busy", bus.tx_busy, 0);
        check("reset_done", bus.tx_done, 0);
        n_rst = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check("idle_line", bus.tx_out, 1);
            check("idle_busy", bus.tx_busy, 0);
            check("idle_done", bus.tx_done, 0);
        end

        // 8'hA5 cycle-exact line pattern
        send(8'hA5);
        for (int c = 1; c <= 100; c++) begin
            check("a5_line", bus.tx_out, pat[(c - 1) / CPB]);
            @(negedge clk);
        end
        check("a5_done_cycle101", bus.tx_done, 1);
        wait_idle(300);

        // Strobe while busy is ignored
        send(8'h00);
        repeat (38) @(negedge clk);
        check("busy_at_restrobe", bus.tx_busy, 1);
        bus.tx_data  = 8'hFF;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        check("restrobe_line_low", bus.tx_out, 0);
        wait_idle(300);

        // Start held high: back-to-back frames
        @(negedge clk);
        bus.tx_data  = 8'h3C;
        bus.tx_start = 1'b1;
        exp_q.push_back(8'h3C);
        done_exp++;
        @(negedge clk);
        bus.tx_data = 8'hC3;
        n = 0;
        while (bus.tx_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_seen", (n < 300), 1);
        exp_q.push_back(8'hC3);
        done_exp++;
        @(negedge clk);
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        check("b2b_second_start", bus.tx_out, 0);
        check("b2b_second_busy", bus.tx_busy, 1);
        wait_idle(300);

        // Reset mid-frame aborts without tx_done
        send(8'h00);
        repeat (54) @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("abort_line_high", bus.tx_out, 1);
        check("abort_busy", bus.tx_busy, 0);
        check("abort_done", bus.tx_done, 0);
        void'(exp_q.pop_back());
        done_exp--;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (60) @(negedge clk);
        check("post_abort_line", bus.tx_out, 1);
        send(8'h5A);
        wait_idle(300);

        // Loopback bytes through receiver model
        send(8'h55);
        wait_idle(300);
        send(8'h00);
        wait_idle(300);
        send(8'hFF);
        wait_idle(300);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("done_count", done_seen, done_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
